// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants, state encoding and address decode for the Hack data-bus arbiter
//
// Contents:
//   SEL_RAM / SEL_IO / SEL_NONE  slave-select codes driven on slaveSel
//   IO_ADDR                      the single mapped I/O register word
//   ST_*                         arbiter FSM state encoding
//   decode_sel()                 word address -> slave-select code

package bus_pkg;

  localparam logic [2:0] SEL_RAM  = 3'b000;
  localparam logic [2:0] SEL_IO   = 3'b010;
  localparam logic [2:0] SEL_NONE = 3'b100;

  localparam logic [15:0] IO_ADDR = 16'h4000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // RAM occupies 0x0000-0x3FFF, the I/O register is exactly 0x4000,
  // everything else is unmapped.
  function automatic logic [2:0] decode_sel(input logic [15:0] addr);
    if (addr[15:14] == 2'b00) begin
      return SEL_RAM;
    end else if (addr == IO_ADDR) begin
      return SEL_IO;
    end else begin
      return SEL_NONE;
    end
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// rtl/bus_rr_pick.sv - combinational two-way round-robin choice
//
// Ports:
//   i_req      [1:0]  request bits, bit 0 = master 0, bit 1 = master 1
//   i_last            master granted most recently (0 or 1)
//   i_ack_mask [1:0]  masters whose ack is high this cycle; never granted
//   o_grant    [1:0]  one-hot grant, 00 when nothing is eligible

module bus_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic [1:0] i_ack_mask,
  output logic [1:0] o_grant
);

  logic [1:0] w_req;

  always_comb begin
    w_req   = i_req & ~i_ack_mask;
    o_grant = 2'b00;
    case (w_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      // On a tie the master that did not win last time goes first.
      2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter and access sequencer for the Hack data bus
//
// Masters: 0 = CPU data port, 1 = program-loader/debug port.
// Slaves : RAM 0x0000-0x3FFF, I/O register 0x4000, all else unmapped.
//
// Parameters:
//   ADDR_W, DATA_W  address / data width
//   TIMEOUT         WAIT cycles before a bus error (only with BUS_TIMEOUT_EN)
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   m0Req/We/Addr/WData        master 0 request (held until m0Ack)
//   m1Req/We/Addr/WData        master 1 request (held until m1Ack)
//   m0Ack/m0RData              master 0 one-cycle ack and read data
//   m1Ack/m1RData              master 1 one-cycle ack and read data
//   sReq                       one-cycle slave strobe
//   sWe/sAddr/sWData           latched access, held until the next grant
//   slaveSel                   000 RAM, 010 I/O, 100 none (100 in IDLE)
//   sRData/sReady              slave read data and completion
//   busErr                     one-cycle error pulse, coincident with ack
//
// Build option: define BUS_TIMEOUT_EN to bound the WAIT state by TIMEOUT cycles.

module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
`ifdef BUS_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0Req,
  input  logic              m0We,
  input  logic [ADDR_W-1:0] m0Addr,
  input  logic [DATA_W-1:0] m0WData,
  input  logic              m1Req,
  input  logic              m1We,
  input  logic [ADDR_W-1:0] m1Addr,
  input  logic [DATA_W-1:0] m1WData,
  output logic              m0Ack,
  output logic [DATA_W-1:0] m0RData,
  output logic              m1Ack,
  output logic [DATA_W-1:0] m1RData,
  output logic              sReq,
  output logic              sWe,
  output logic [ADDR_W-1:0] sAddr,
  output logic [DATA_W-1:0] sWData,
  output logic [2:0]        slaveSel,
  input  logic [DATA_W-1:0] sRData,
  input  logic              sReady,
  output logic              busErr
);

  logic [1:0]        r_state;
  logic [1:0]        r_gnt;
  logic              r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_sel;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [1:0]        w_grant;
  logic [1:0]        w_ack_mask;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [2:0]        w_sel;

  assign w_ack_mask = {m1Ack, m0Ack};

  bus_rr_pick u_pick (
    .i_req      ({m1Req, m0Req}),
    .i_last     (r_last),
    .i_ack_mask (w_ack_mask),
    .o_grant    (w_grant)
  );

  assign w_we    = w_grant[1] ? m1We    : m0We;
  assign w_addr  = w_grant[1] ? m1Addr  : m0Addr;
  assign w_wdata = w_grant[1] ? m1WData : m0WData;
  assign w_sel   = decode_sel(16'(w_addr));

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= SEL_NONE;
      r_rdata <= '0;
      r_err   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant != 2'b00) begin
            r_gnt   <= w_grant;
            r_last  <= w_grant[1];
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_sel   <= w_sel;
            r_err   <= (w_sel == SEL_NONE);
            r_rdata <= '0;
            r_state <= ST_ISSUE;
          end
        end
        // An unmapped access spends this slot with sReq suppressed and
        // goes straight to RESP, giving its ack one cycle after the grant.
        ST_ISSUE: begin
`ifdef BUS_TIMEOUT_EN
          r_cnt   <= '0;
`endif
          r_state <= r_err ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          if (sReady) begin
            r_rdata <= r_we ? '0 : sRData;
            r_state <= ST_RESP;
          end
`ifdef BUS_TIMEOUT_EN
          else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sReq     = (r_state == ST_ISSUE) && !r_err;
  assign sWe      = r_we;
  assign sAddr    = r_addr;
  assign sWData   = r_wdata;
  assign slaveSel = (r_state == ST_IDLE) ? SEL_NONE : r_sel;

  assign m0Ack   = (r_state == ST_RESP) && r_gnt[0];
  assign m1Ack   = (r_state == ST_RESP) && r_gnt[1];
  assign m0RData = m0Ack ? r_rdata : '0;
  assign m1RData = m1Ack ? r_rdata : '0;
  assign busErr  = (r_state == ST_RESP) && r_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard testbench for bus_arbiter

module tb_bus_arbiter;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0Req = 0, m0We = 0, m1Req = 0, m1We = 0;
  logic [15:0] m0Addr = 0, m0WData = 0, m1Addr = 0, m1WData = 0;
  logic        m0Ack, m1Ack, sReq, sWe, busErr;
  logic [15:0] m0RData, m1RData, sAddr, sWData;
  logic [2:0]  slaveSel;
  logic [15:0] sRData = 0;
  logic        sReady = 0;

  bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0Req(m0Req), .m0We(m0We), .m0Addr(m0Addr), .m0WData(m0WData),
    .m1Req(m1Req), .m1We(m1We), .m1Addr(m1Addr), .m1WData(m1WData),
    .m0Ack(m0Ack), .m0RData(m0RData), .m1Ack(m1Ack), .m1RData(m1RData),
    .sReq(sReq), .sWe(sWe), .sAddr(sAddr), .sWData(sWData),
    .slaveSel(slaveSel), .sRData(sRData), .sReady(sReady), .busErr(busErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    bit          master;
    logic [15:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Slave model: answers one cycle after sReq with slave_data when auto_ready.
  bit          auto_ready = 1'b1;
  logic [15:0] slave_data = 16'h0000;
  initial begin
    bit saw;
    forever begin
      @(negedge clk);
      saw = sReq;
      @(posedge clk);
      #1;
      sReady = 1'b0;
      sRData = 16'h0000;
      if (saw && auto_ready) begin
        sReady = 1'b1;
        sRData = slave_data;
      end
    end
  end

  // Monitor: scoreboard pop on every ack, plus slave-side captures.
  int          sreq_cnt = 0;
  int          sel_active = 0;
  logic [2:0]  cap_sel;
  logic        cap_we;
  logic [15:0] cap_addr, cap_wdata;

  always @(negedge clk) begin
    if (!reset) begin
      if (sReq) begin
        sreq_cnt++;
        cap_sel   = slaveSel;
        cap_we    = sWe;
        cap_addr  = sAddr;
        cap_wdata = sWData;
      end
      if (slaveSel != SEL_NONE) sel_active++;
      if (m0Ack || m1Ack) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_ack: got acks %b expected none (cycle %0d)", {m1Ack, m0Ack}, cyc);
        end else begin
          e = sb.pop_front();
          check("ack_master", {30'd0, m1Ack, m0Ack}, e.master ? 32'd2 : 32'd1);
          check("ack_cycle", cyc, e.cyc);
          check("ack_rdata", {16'd0, e.master ? m1RData : m0RData}, {16'd0, e.rdata});
          check("other_rdata", {16'd0, e.master ? m0RData : m1RData}, 32'd0);
          check("ack_busErr", {31'd0, busErr}, {31'd0, e.err});
        end
      end else if (busErr) begin
        n_vec++;
        n_miss++;
        $display("FAIL stray_busErr: got 1 expected 0 (cycle %0d)", cyc);
      end
    end
  end

  task automatic set_req(input bit m, input bit we, input logic [15:0] addr, input logic [15:0] wd);
    if (m) begin
      m1Req = 1'b1; m1We = we; m1Addr = addr; m1WData = wd;
    end else begin
      m0Req = 1'b1; m0We = we; m0Addr = addr; m0WData = wd;
    end
  endtask

  task automatic do_req(input bit m, input bit we, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_rdata, input bit exp_err);
    exp_t x;
    bit   got;
    @(posedge clk);
    #1;
    set_req(m, we, addr, wd);
    x.master = m;
    x.rdata  = exp_rdata;
    x.err    = exp_err;
    x.cyc    = cyc + (exp_err ? 2 : 3);
    sb.push_back(x);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (m ? m1Ack : m0Ack) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("FAIL ack_timeout: master %0d addr %h got no ack expected ack within 60 cycles", m, addr);
      sb.delete();
    end
    @(posedge clk);
    #1;
    m0Req = 1'b0;
    m1Req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m0Ack"}, {31'd0, m0Ack}, 32'd0);
    check({tag, "_m1Ack"}, {31'd0, m1Ack}, 32'd0);
    check({tag, "_sReq"}, {31'd0, sReq}, 32'd0);
    check({tag, "_busErr"}, {31'd0, busErr}, 32'd0);
    check({tag, "_slaveSel"}, {29'd0, slaveSel}, {29'd0, SEL_NONE});
    check({tag, "_sWe"}, {31'd0, sWe}, 32'd0);
    check({tag, "_sAddr"}, {16'd0, sAddr}, 32'd0);
    check({tag, "_sWData"}, {16'd0, sWData}, 32'd0);
    check({tag, "_m0RData"}, {16'd0, m0RData}, 32'd0);
    check({tag, "_m1RData"}, {16'd0, m1RData}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, a0, n;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // m0 reads 0x0123, slave answers 0xBEEF one cycle after sReq.
    slave_data = 16'hBEEF;
    do_req(1'b0, 1'b0, 16'h0123, 16'h0000, 16'hBEEF, 1'b0);

    // m0 writes the I/O register.
    s0 = sreq_cnt;
    do_req(1'b0, 1'b1, 16'h4000, 16'h0055, 16'h0000, 1'b0);
    check("io_sreq_pulses", sreq_cnt - s0, 32'd1);
    check("io_slaveSel", {29'd0, cap_sel}, {29'd0, SEL_IO});
    check("io_sWe", {31'd0, cap_we}, 32'd1);
    check("io_sAddr", {16'd0, cap_addr}, 32'h4000);
    check("io_sWData", {16'd0, cap_wdata}, 32'h0055);

    // m1 writes unmapped 0x7FFF: no strobe, slaveSel stays 100.
    s0 = sreq_cnt;
    a0 = sel_active;
    do_req(1'b1, 1'b1, 16'h7FFF, 16'h1111, 16'h0000, 1'b1);
    check("unmapped_sreq", sreq_cnt - s0, 32'd0);
    check("unmapped_sel", sel_active - a0, 32'd0);

    // 0x4001 is just past the I/O word: unmapped read returns 0.
    slave_data = 16'hDEAD;
    do_req(1'b0, 1'b0, 16'h4001, 16'h0000, 16'h0000, 1'b1);

    // 0x3FFF is the last RAM word.
    slave_data = 16'h5A5A;
    s0 = sreq_cnt;
    do_req(1'b1, 1'b0, 16'h3FFF, 16'h0000, 16'h5A5A, 1'b0);
    check("ram_top_sreq", sreq_cnt - s0, 32'd1);
    check("ram_top_sel", {29'd0, cap_sel}, {29'd0, SEL_RAM});

    // Both masters request continuously: m0, m1, m0, m1 every 4 cycles.
    slave_data = 16'hC0DE;
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 16'h0010, 16'h0000);
    set_req(1'b1, 1'b1, 16'h0020, 16'h9999);
    n = cyc;
    sb.push_back('{1'b0, 16'hC0DE, 1'b0, n + 3});
    sb.push_back('{1'b1, 16'h0000, 1'b0, n + 7});
    sb.push_back('{1'b0, 16'hC0DE, 1'b0, n + 11});
    sb.push_back('{1'b1, 16'h0000, 1'b0, n + 15});
    repeat (16) @(posedge clk);
    #1;
    m0Req = 1'b0;
    m1Req = 1'b0;
    repeat (4) @(posedge clk);
    check("rr_drained", sb.size(), 32'd0);

    // Reset while stuck in WAIT: transaction dropped, outputs clear at once.
    auto_ready = 1'b0;
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 16'h0100, 16'h0000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    m0Req = 1'b0;
    auto_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First tie after reset goes to m0 even though m0 won last before reset.
    slave_data = 16'h0F0F;
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 16'h0200, 16'h0000);
    set_req(1'b1, 1'b0, 16'h0300, 16'h0000);
    n = cyc;
    sb.push_back('{1'b0, 16'h0F0F, 1'b0, n + 3});
    sb.push_back('{1'b1, 16'h0F0F, 1'b0, n + 7});
    repeat (8) @(posedge clk);
    #1;
    m0Req = 1'b0;
    m1Req = 1'b0;
    repeat (5) @(posedge clk);
    check("final_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
